// File: rtl/cpu_csr_access.sv
// cpu_csr_access: Zicsr instruction sequencer acting as the initiator on the
// CSR file port. Performs a read cycle, an optional write cycle, and reports
// the old CSR value for rd or an illegal-instruction exception.
module cpu_csr_access (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_addr,
    input  logic [4:0]  rs1_idx,
    input  logic [31:0] rs1_val,
    input  logic [4:0]  rd_idx,
    input  logic [31:0] inst,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd_val,
    output logic        rd_wr,
    output logic        illegal,
    output logic [31:0] exc_cause,
    output logic [31:0] exc_value,
    output logic [11:0] csr_addr_o,
    input  logic [31:0] csr_rdata,
    input  logic        csr_allowed,
    output logic [31:0] csr_wdata,
    output logic        csr_wr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state;
    logic [2:0]  f3_q;
    logic [11:0] addr_q;
    logic [4:0]  uimm_q;
    logic [31:0] rs1_val_q;
    logic [4:0]  rd_idx_q;
    logic [31:0] inst_q;
    logic [31:0] old_q;
    logic [31:0] new_q;
    logic [31:0] rd_val_q;
    logic        rd_wr_q;
    logic        ill_q;
    logic [31:0] cause_q;
    logic [31:0] value_q;

    logic [31:0] operand;
    logic [31:0] new_val;
    logic        wants_write;
    logic        ill_now;

    // Read-cycle evaluation: operand select, new value, write intent, legality
    always_comb begin
        operand     = f3_q[2] ? {27'b0, uimm_q} : rs1_val_q;
        new_val     = operand;
        case (f3_q[1:0])
            2'b10:   new_val = csr_rdata | operand;
            2'b11:   new_val = csr_rdata & ~operand;
            default: new_val = operand;
        endcase
        wants_write = (f3_q[1:0] == 2'b01) || (uimm_q != 5'd0);
        ill_now     = (f3_q[1:0] == 2'b00) || !csr_allowed ||
                      (wants_write && (addr_q[11:10] == 2'b11));
    end

    // Sequencer state, operand latches and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            f3_q      <= '0;
            addr_q    <= '0;
            uimm_q    <= '0;
            rs1_val_q <= '0;
            rd_idx_q  <= '0;
            inst_q    <= '0;
            old_q     <= '0;
            new_q     <= '0;
            rd_val_q  <= '0;
            rd_wr_q   <= 1'b0;
            ill_q     <= 1'b0;
            cause_q   <= '0;
            value_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        f3_q      <= funct3;
                        addr_q    <= csr_addr;
                        uimm_q    <= rs1_idx;
                        rs1_val_q <= rs1_val;
                        rd_idx_q  <= rd_idx;
                        inst_q    <= inst;
                        state     <= S_READ;
                    end
                end
                S_READ: begin
                    old_q <= csr_rdata;
                    new_q <= new_val;
                    if (wants_write && !ill_now) begin
                        state <= S_WRITE;
                    end else begin
                        // No write cycle: results are loaded now so they appear with done
                        state    <= S_DONE;
                        rd_val_q <= ill_now ? 32'd0 : csr_rdata;
                        rd_wr_q  <= !ill_now && (rd_idx_q != 5'd0);
                        ill_q    <= ill_now;
                        cause_q  <= ill_now ? 32'd2 : 32'd0;
                        value_q  <= ill_now ? inst_q : 32'd0;
                    end
                end
                S_WRITE: begin
                    state    <= S_DONE;
                    rd_val_q <= old_q;
                    rd_wr_q  <= (rd_idx_q != 5'd0);
                    ill_q    <= 1'b0;
                    cause_q  <= '0;
                    value_q  <= '0;
                end
                default: begin
                    state    <= S_IDLE;
                    rd_val_q <= '0;
                    rd_wr_q  <= 1'b0;
                    ill_q    <= 1'b0;
                    cause_q  <= '0;
                    value_q  <= '0;
                end
            endcase
        end
    end

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign csr_wr     = (state == S_WRITE);
    assign csr_wdata  = new_q;
    assign csr_addr_o = addr_q;
    assign rd_val     = rd_val_q;
    assign rd_wr      = rd_wr_q;
    assign illegal    = ill_q;
    assign exc_cause  = cause_q;
    assign exc_value  = value_q;

endmodule

// File: tb/tb_cpu_csr_access.sv
// tb_cpu_csr_access: directed self-checking bench for cpu_csr_access with a
// small behavioural CSR file model on the initiator port.
module tb_cpu_csr_access;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_val;
    logic [4:0]  rd_idx;
    logic [31:0] inst;
    logic        busy;
    logic        done;
    logic [31:0] rd_val;
    logic        rd_wr;
    logic        illegal;
    logic [31:0] exc_cause;
    logic [31:0] exc_value;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_rdata;
    logic        csr_allowed;
    logic [31:0] csr_wdata;
    logic        csr_wr;

    int n_cmp;
    int n_bad;

    // CSR file model
    logic [31:0] mem [0:4095];
    logic        pre_en;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;

    cpu_csr_access dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .funct3      (funct3),
        .csr_addr    (csr_addr),
        .rs1_idx     (rs1_idx),
        .rs1_val     (rs1_val),
        .rd_idx      (rd_idx),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .rd_val      (rd_val),
        .rd_wr       (rd_wr),
        .illegal     (illegal),
        .exc_cause   (exc_cause),
        .exc_value   (exc_value),
        .csr_addr_o  (csr_addr_o),
        .csr_rdata   (csr_rdata),
        .csr_allowed (csr_allowed),
        .csr_wdata   (csr_wdata),
        .csr_wr      (csr_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign csr_rdata = mem[csr_addr_o];

    always @(posedge clk) begin
        if (pre_en)      mem[pre_addr]   <= pre_data;
        else if (csr_wr) mem[csr_addr_o] <= csr_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preset(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // results captured by run
    int          lat;
    int          wcnt;
    logic [31:0] wd;
    logic [31:0] r_rdval;
    logic        r_rdwr;
    logic        r_ill;
    logic [31:0] r_cause;
    logic [31:0] r_value;
    logic        got;
    logic        post_done;
    logic        post_busy;

    task automatic run(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] ri,
                       input logic [31:0] rv, input logic [4:0] rd, input logic [31:0] iw,
                       input bit pulse_busy);
        @(negedge clk);
        start = 1'b1; funct3 = f3; csr_addr = a; rs1_idx = ri; rs1_val = rv; rd_idx = rd; inst = iw;
        @(negedge clk);
        start = 1'b0; funct3 = 3'b000; csr_addr = 12'h000; rs1_idx = 5'd0; rs1_val = '0;
        rd_idx = 5'd0; inst = '0;
        lat = 1; wcnt = 0; wd = '0; got = 1'b0;
        r_rdval = '0; r_rdwr = 1'b0; r_ill = 1'b0; r_cause = '0; r_value = '0;
        for (int i = 0; i < 10; i++) begin
            if (csr_wr) begin
                wcnt++;
                wd = csr_wdata;
            end
            if (done) begin
                got = 1'b1;
                r_rdval = rd_val; r_rdwr = rd_wr; r_ill = illegal;
                r_cause = exc_cause; r_value = exc_value;
                break;
            end
            if (pulse_busy && lat == 1) begin
                start = 1'b1; funct3 = 3'b001; csr_addr = 12'h300; rs1_idx = 5'd1;
                rs1_val = 32'hFFFF_FFFF; rd_idx = 5'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("timeout", {31'd0, got}, 32'd1);
        @(negedge clk);
        post_done = done;
        post_busy = busy;
    endtask

    task automatic expect_res(input string tag, input int e_lat, input int e_wcnt,
                              input logic [31:0] e_wd, input logic [31:0] e_rdval,
                              input logic e_rdwr, input logic e_ill, input logic [31:0] e_value);
        chk({tag, ".lat"},    lat,  e_lat);
        chk({tag, ".wcnt"},   wcnt, e_wcnt);
        if (e_wcnt != 0) chk({tag, ".wdata"}, wd, e_wd);
        chk({tag, ".rd_val"}, r_rdval, e_rdval);
        chk({tag, ".rd_wr"},  {31'd0, r_rdwr}, {31'd0, e_rdwr});
        chk({tag, ".ill"},    {31'd0, r_ill},  {31'd0, e_ill});
        chk({tag, ".cause"},  r_cause, e_ill ? 32'd2 : 32'd0);
        chk({tag, ".value"},  r_value, e_value);
        chk({tag, ".one_done"}, {30'd0, post_done, post_busy}, 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; start = 1'b0; funct3 = '0; csr_addr = '0; rs1_idx = '0; rs1_val = '0;
        rd_idx = '0; inst = '0; csr_allowed = 1'b1;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;

        @(negedge clk); @(negedge clk);
        chk("rst.busy",   {31'd0, busy},   32'd0);
        chk("rst.done",   {31'd0, done},   32'd0);
        chk("rst.csr_wr", {31'd0, csr_wr}, 32'd0);
        chk("rst.outs",   rd_val | exc_cause | exc_value | csr_wdata | {20'd0, csr_addr_o}, 32'd0);
        chk("rst.flags",  {30'd0, rd_wr, illegal}, 32'd0);
        rst_n = 1'b1;

        // CSRRW: old 0x11 returned, new value written once
        preset(12'h140, 32'h0000_0011);
        run(3'b001, 12'h140, 5'd1, 32'hDEAD_BEEF, 5'd5, 32'h1400_92F3, 1'b0);
        expect_res("rw", 3, 1, 32'hDEAD_BEEF, 32'h11, 1'b1, 1'b0, 32'd0);
        chk("rw.mem", mem[12'h140], 32'hDEAD_BEEF);

        // CSRRS / CSRRC / CSRRSI sequence on 0x100
        preset(12'h100, 32'h0000_0020);
        run(3'b010, 12'h100, 5'd3, 32'h2, 5'd6, 32'h1001_A373, 1'b0);
        expect_res("rs", 3, 1, 32'h22, 32'h20, 1'b1, 1'b0, 32'd0);
        run(3'b011, 12'h100, 5'd4, 32'h20, 5'd7, 32'h1002_33F3, 1'b0);
        expect_res("rc", 3, 1, 32'h02, 32'h22, 1'b1, 1'b0, 32'd0);
        run(3'b110, 12'h100, 5'd0, 32'hFFFF_FFFF, 5'd8, 32'h1000_6473, 1'b0);
        expect_res("rsi0", 2, 0, 32'd0, 32'h02, 1'b1, 1'b0, 32'd0);
        run(3'b110, 12'h100, 5'd5, 32'h0, 5'd8, 32'h1002_E473, 1'b0);
        expect_res("rsi5", 3, 1, 32'h07, 32'h02, 1'b1, 1'b0, 32'd0);

        // read-only CSR: read legal, write illegal
        preset(12'hC00, 32'h0000_1234);
        run(3'b010, 12'hC00, 5'd0, 32'h0000_FFFF, 5'd9, 32'hC000_24F3, 1'b0);
        expect_res("ro_rd", 2, 0, 32'd0, 32'h1234, 1'b1, 1'b0, 32'd0);
        run(3'b001, 12'hC00, 5'd2, 32'h5555_0000, 5'd9, 32'hC001_14F3, 1'b0);
        expect_res("ro_wr", 2, 0, 32'd0, 32'd0, 1'b0, 1'b1, 32'hC001_14F3);
        chk("ro_wr.mem", mem[12'hC00], 32'h1234);

        // privilege denial and reserved funct3
        csr_allowed = 1'b0;
        run(3'b001, 12'h141, 5'd2, 32'h0BAD_0BAD, 5'd3, 32'h1411_11F3, 1'b0);
        expect_res("deny", 2, 0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h1411_11F3);
        csr_allowed = 1'b1;
        run(3'b100, 12'h140, 5'd2, 32'h1, 5'd3, 32'h1401_41F3, 1'b0);
        expect_res("f3_100", 2, 0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h1401_41F3);

        // rd = x0 write, with start pulsed while busy
        run(3'b001, 12'h140, 5'd1, 32'h55, 5'd0, 32'h1400_9073, 1'b1);
        expect_res("rd0", 3, 1, 32'h55, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
        chk("busy_start.mem300", mem[12'h300], 32'd0);

        // reset asserted during WRITE
        @(negedge clk);
        start = 1'b1; funct3 = 3'b001; csr_addr = 12'h140; rs1_idx = 5'd1;
        rs1_val = 32'hAAAA_5555; rd_idx = 5'd4; inst = 32'h1400_9273;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rstw.in_write", {31'd0, csr_wr}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw.csr_wr", {31'd0, csr_wr}, 32'd0);
        chk("rstw.ctl",    {29'd0, busy, done, rd_wr}, 32'd0);
        chk("rstw.data",   rd_val | csr_wdata | exc_value | {20'd0, csr_addr_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstw.mem", mem[12'h140], 32'h55);
        @(negedge clk);
        chk("rstw.idle", {31'd0, busy}, 32'd0);
        run(3'b001, 12'h140, 5'd1, 32'h77, 5'd10, 32'h1400_9573, 1'b0);
        expect_res("post_rst", 3, 1, 32'h77, 32'h55, 1'b1, 1'b0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_csr_access.md
# cpu_csr_access

Sequencer that executes Zicsr instructions (CSRRW/RS/RC and immediate forms) against the CPU's CSR file, acting as the initiator side of the CSR port. It takes a decoded instruction from the execute stage and performs a read cycle, then an optional write cycle, on the CSR address/data/write/allowed interface. It returns the old CSR value for rd, or flags an illegal-instruction exception with cause and value ready for the trap logic.

## Interface
- Parameters: none.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  instruction valid; sampled only in IDLE.
- funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 illegal.
- csr_addr  in  12  CSR number from inst[31:20].
- rs1_idx  in  5  rs1 index; doubles as uimm for immediate forms.
- rs1_val  in  32  rs1 register value.
- rd_idx  in  5  destination index.
- inst  in  32  raw instruction word, reported as exc_value.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- rd_val  out  32  old CSR value; valid with done.
- rd_wr  out  1  write rd_val to rd_idx; valid with done.
- illegal  out  1  illegal-instruction exception; valid with done.
- exc_cause  out  32  32'd2 when illegal, else 0.
- exc_value  out  32  latched inst when illegal, else 0.
- csr_addr_o  out  12  address to CSR file; holds latched csr_addr.
- csr_rdata  in  32  CSR file combinational read data.
- csr_allowed  in  1  CSR file privilege check for csr_addr_o.
- csr_wdata  out  32  new CSR value.
- csr_wr  out  1  CSR write strobe; high only in WRITE.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: if start, latch funct3, csr_addr, rs1_idx, rs1_val, rd_idx, inst; go to READ. If start is low, stay.
- READ: drive csr_addr_o and capture old = csr_rdata. Then evaluate:
  - operand = funct3[2] ? {27'b0, rs1_idx} : rs1_val.
  - new value: RW = operand; RS = old | operand; RC = old & ~operand.
  - wants_write = RW/RWI always; RS/RC/RSI/RCI only if rs1_idx != 0.
  - illegal = funct3 in {000, 100} OR !csr_allowed OR (wants_write AND csr_addr[11:10] == 2'b11).
  - If wants_write and not illegal, go to WRITE; otherwise go to DONE.
- WRITE: csr_wr = 1, csr_wdata = registered new value; go to DONE.
- DONE: done = 1; go to IDLE.
  - Legal: rd_val = old, rd_wr = (rd_idx != 0), illegal = 0.
  - Illegal: rd_wr = 0, rd_val = 0, illegal = 1, exc_cause = 2, exc_value = latched inst.
- start while busy is ignored; there is no queueing.
- An illegal access never asserts csr_wr.

## Timing
- Edge E0 samples start in IDLE. E1 leaves READ. With a write, E2 leaves WRITE.
- csr_wr is high for exactly the cycle between E1 and E2, so the CSR file commits at E2.
- done is high in the cycle after E2 (write path) or after E1 (no-write or illegal path). Latency from start is 3 cycles with a write and 2 without.
- The next start is accepted in the cycle after done (IDLE).
- csr_rdata and csr_allowed are sampled only at the edge ending READ.
- rd_val, rd_wr, illegal, exc_cause and exc_value are registered. They are valid only while done is high; otherwise they are 0.
- Reset (asynchronous, any state):
  - state = IDLE.
  - busy, done, rd_wr, illegal, csr_wr = 0.
  - rd_val, exc_cause, exc_value, csr_wdata, csr_addr_o and all latches = 0.
  - If reset arrives in WRITE, csr_wr drops immediately and no write completes.
  - After rst_n deasserts, the block waits for a fresh start.

## Test plan
- CSRRW 0x140, rs1_val=0xDEADBEEF, rd=5, CSR holds 0x11 -> csr_wr for 1 cycle with 0xDEADBEEF; done 3 cycles after start; rd_val=0x11, rd_wr=1.
- CSRRS 0x100, rs1_val=0x2, CSR=0x20 -> wdata=0x22. Then CSRRC 0x100, rs1_val=0x20 -> wdata=0x02. CSRRSI with uimm=0 -> no csr_wr, done at 2 cycles.
- CSRRS 0xC00 (cycle), rs1=x0 -> legal read, rd_val=CSR value, no write. CSRRW 0xC00 -> illegal=1, exc_cause=2, exc_value=inst, csr_wr never asserted.
- csr_allowed=0 on CSRRW 0x141 -> illegal, no write, rd_wr=0. funct3=100 -> illegal.
- rd=x0 CSRRW -> write occurs, rd_wr=0. start pulsed while busy -> ignored; exactly one done.
- rst_n low during WRITE -> csr_wr falls asynchronously, all outputs 0. After release, a new CSRRW completes normally.
